// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares the single combinational ALU of the MUSA core between two
//   requesters (0: execute stage, 1: branch/address unit). A combinational
//   round-robin arbiter picks at most one requester per cycle and drives
//   that requester's operands onto the ALU. The ALU result and flags are
//   captured on the following clock edge into a per-requester response
//   register. That register is held until the requester consumes it.
//
// Optional feature (macro ALU_ARB_LOCK_EN):
//   Adds req0_lock / req1_lock. A grant with lock set makes the arbiter
//   serve only that requester until it is granted again with lock clear.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   reqN_valid/op1/op2/func     request from requester N (not registered)
//   reqN_ready                  grant to N this cycle (combinational)
//   reqN_lock                   lock request (ALU_ARB_LOCK_EN only)
//   rspN_valid/result/flags     response register, flags = {ovf, zero, eq, above}
//   rspN_ready                  requester N consumes the response this cycle
//   alu_op1/op2/func            ALU operand drive, zero when idle
//   alu_result, alu_overflow, alu_zero, alu_equals, alu_above  ALU outputs
module alu_arbiter #(
  parameter int WIDTH  = 32,
  parameter int FUNC_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [WIDTH-1:0]  req0_op1,
  input  logic [WIDTH-1:0]  req0_op2,
  input  logic [FUNC_W-1:0] req0_func,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [WIDTH-1:0]  req1_op1,
  input  logic [WIDTH-1:0]  req1_op2,
  input  logic [FUNC_W-1:0] req1_func,
  output logic              req1_ready,
`ifdef ALU_ARB_LOCK_EN
  input  logic              req0_lock,
  input  logic              req1_lock,
`endif
  output logic              rsp0_valid,
  output logic [WIDTH-1:0]  rsp0_result,
  output logic [3:0]        rsp0_flags,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  output logic [WIDTH-1:0]  rsp1_result,
  output logic [3:0]        rsp1_flags,
  input  logic              rsp1_ready,
  output logic [WIDTH-1:0]  alu_op1,
  output logic [WIDTH-1:0]  alu_op2,
  output logic [FUNC_W-1:0] alu_func,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_overflow,
  input  logic              alu_zero,
  input  logic              alu_equals,
  input  logic              alu_above
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_t;

  slot_t             slot0_p1, slot0_nxt;
  slot_t             slot1_p1, slot1_nxt;
  logic              last_grant_p1;
  logic [WIDTH-1:0]  rsp0_result_p1, rsp1_result_p1;
  logic [3:0]        rsp0_flags_p1, rsp1_flags_p1;
  logic              elig0, elig1;
  logic              allow0, allow1;
  logic              grant0, grant1;

`ifdef ALU_ARB_LOCK_EN
  logic locked_p1;
  logic lock_owner_p1;
`endif

  // ---- stage p0: eligibility, grant and ALU drive (combinational) ----
  always_comb begin
    allow0 = 1'b1;
    allow1 = 1'b1;
`ifdef ALU_ARB_LOCK_EN
    // While locked, the non-owner is masked out even if eligible.
    if (locked_p1) begin
      allow0 = (lock_owner_p1 == 1'b0);
      allow1 = (lock_owner_p1 == 1'b1);
    end
`endif
    // A full slot that is being consumed this cycle can accept a new result.
    elig0  = req0_valid && ((slot0_p1 == EMPTY) || rsp0_ready) && allow0;
    elig1  = req1_valid && ((slot1_p1 == EMPTY) || rsp1_ready) && allow1;
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      if (elig0 && elig1) begin
        grant0 = last_grant_p1;
        grant1 = !last_grant_p1;
      end else begin
        grant0 = elig0;
        grant1 = elig1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    alu_op1  = '0;
    alu_op2  = '0;
    alu_func = '0;
    if (grant0) begin
      alu_op1  = req0_op1;
      alu_op2  = req0_op2;
      alu_func = req0_func;
    end else if (grant1) begin
      alu_op1  = req1_op1;
      alu_op2  = req1_op2;
      alu_func = req1_func;
    end
  end

  // Response slot next state: a grant always fills (or overwrites) the slot.
  always_comb begin
    slot0_nxt = slot0_p1;
    slot1_nxt = slot1_p1;
    if (grant0)
      slot0_nxt = FULL;
    else if ((slot0_p1 == FULL) && rsp0_ready)
      slot0_nxt = EMPTY;
    if (grant1)
      slot1_nxt = FULL;
    else if ((slot1_p1 == FULL) && rsp1_ready)
      slot1_nxt = EMPTY;
  end

  // ---- stage p1: response capture registers ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot0_p1       <= EMPTY;
      slot1_p1       <= EMPTY;
      last_grant_p1  <= 1'b1;
      rsp0_result_p1 <= '0;
      rsp1_result_p1 <= '0;
      rsp0_flags_p1  <= '0;
      rsp1_flags_p1  <= '0;
    end else begin
      slot0_p1 <= slot0_nxt;
      slot1_p1 <= slot1_nxt;
      if (grant0) begin
        rsp0_result_p1 <= alu_result;
        rsp0_flags_p1  <= {alu_overflow, alu_zero, alu_equals, alu_above};
        last_grant_p1  <= 1'b0;
      end else if (grant1) begin
        rsp1_result_p1 <= alu_result;
        rsp1_flags_p1  <= {alu_overflow, alu_zero, alu_equals, alu_above};
        last_grant_p1  <= 1'b1;
      end
    end
  end

`ifdef ALU_ARB_LOCK_EN
  // Only the owner can be granted while locked, so any grant simply
  // (re)loads the lock state from that requester's lock bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      locked_p1     <= 1'b0;
      lock_owner_p1 <= 1'b0;
    end else if (grant0) begin
      locked_p1     <= req0_lock;
      lock_owner_p1 <= 1'b0;
    end else if (grant1) begin
      locked_p1     <= req1_lock;
      lock_owner_p1 <= 1'b1;
    end
  end
`endif

  assign rsp0_valid  = (slot0_p1 == FULL);
  assign rsp1_valid  = (slot1_p1 == FULL);
  assign rsp0_result = rsp0_result_p1;
  assign rsp1_result = rsp1_result_p1;
  assign rsp0_flags  = rsp0_flags_p1;
  assign rsp1_flags  = rsp1_flags_p1;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic [2:0]  req0_func, req1_func;
  logic        req0_ready, req1_ready;
  logic        req0_lock, req1_lock;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_result, rsp1_result;
  logic [3:0]  rsp0_flags, rsp1_flags;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] alu_op1, alu_op2, alu_result;
  logic [2:0]  alu_func;
  logic        alu_overflow, alu_zero, alu_equals, alu_above;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // ALU stub: add, with simple flag derivation.
  assign alu_result   = alu_op1 + alu_op2;
  assign alu_zero     = (alu_result == 32'd0);
  assign alu_equals   = (alu_op1 == alu_op2);
  assign alu_above    = (alu_op1 > alu_op2);
  assign alu_overflow = 1'b0;

  alu_arbiter #(.WIDTH(32), .FUNC_W(3)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_op1(req0_op1), .req0_op2(req0_op2),
    .req0_func(req0_func), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op1(req1_op1), .req1_op2(req1_op2),
    .req1_func(req1_func), .req1_ready(req1_ready),
`ifdef ALU_ARB_LOCK_EN
    .req0_lock(req0_lock), .req1_lock(req1_lock),
`endif
    .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags),
    .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags),
    .rsp1_ready(rsp1_ready),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_func(alu_func),
    .alu_result(alu_result), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
    .alu_equals(alu_equals), .alu_above(alu_above)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 0; req1_valid = 0;
    req0_op1 = 0; req0_op2 = 0; req0_func = 0;
    req1_op1 = 0; req1_op2 = 0; req1_func = 0;
    req0_lock = 0; req1_lock = 0;
    rsp0_ready = 0; rsp1_ready = 0;

    // Reset state; a valid request is not granted while in reset.
    #2 req0_valid = 1;
    #1;
    check("rst_req0_ready", 32'(req0_ready), 32'd0);
    check("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    check("rst_rsp0_result", rsp0_result, 32'd0);
    check("rst_rsp0_flags", 32'(rsp0_flags), 32'd0);
    check("rst_alu_op1", alu_op1, 32'd0);
    req0_valid = 0;
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Contention after reset: req0 wins first, then round robin.
    req0_valid = 1; req0_op1 = 1;  req0_op2 = 2;  req0_func = 3'd1;
    req1_valid = 1; req1_op1 = 10; req1_op2 = 20; req1_func = 3'd2;
    rsp0_ready = 1; rsp1_ready = 1;
    #1;
    check("cont_req0_ready", 32'(req0_ready), 32'd1);
    check("cont_req1_ready", 32'(req1_ready), 32'd0);
    check("cont_alu_op1", alu_op1, 32'd1);
    check("cont_alu_op2", alu_op2, 32'd2);
    check("cont_alu_func", 32'(alu_func), 32'd1);
    tick();
    check("cont_rsp0_valid", 32'(rsp0_valid), 32'd1);
    check("cont_rsp0_result", rsp0_result, 32'd3);
    check("cont_rsp1_valid0", 32'(rsp1_valid), 32'd0);
    req0_op1 = 2; req0_op2 = 2;
    #1;
    check("cont2_req1_ready", 32'(req1_ready), 32'd1);
    check("cont2_req0_ready", 32'(req0_ready), 32'd0);
    check("cont2_alu_op1", alu_op1, 32'd10);
    check("cont2_alu_func", 32'(alu_func), 32'd2);
    tick();
    check("cont2_rsp1_valid", 32'(rsp1_valid), 32'd1);
    check("cont2_rsp1_result", rsp1_result, 32'd30);
    check("cont2_rsp0_consumed", 32'(rsp0_valid), 32'd0);
    req1_valid = 0;
    #1;
    check("cont3_req0_ready", 32'(req0_ready), 32'd1);
    tick();
    check("cont3_rsp0_result", rsp0_result, 32'd4);
    check("cont3_rsp0_flags", 32'(rsp0_flags), 32'h2);
    check("cont3_rsp1_consumed", 32'(rsp1_valid), 32'd0);
    req0_valid = 0;
    tick();
    check("cont3_rsp0_consumed", 32'(rsp0_valid), 32'd0);

    // Single request, response held without rsp0_ready.
    rsp0_ready = 0; rsp1_ready = 0;
    req0_valid = 1; req0_op1 = 5; req0_op2 = 7; req0_func = 3'd3;
    #1;
    check("single_req0_ready", 32'(req0_ready), 32'd1);
    check("single_req1_ready", 32'(req1_ready), 32'd0);
    tick();
    req0_valid = 0;
    check("single_rsp0_valid", 32'(rsp0_valid), 32'd1);
    check("single_rsp0_result", rsp0_result, 32'd12);
    check("single_rsp0_flags", 32'(rsp0_flags), 32'd0);
    check("single_rsp1_valid", 32'(rsp1_valid), 32'd0);
    #1;
    check("idle_alu_op1", alu_op1, 32'd0);
    check("idle_alu_func", 32'(alu_func), 32'd0);
    tick();
    check("single_hold_valid", 32'(rsp0_valid), 32'd1);
    check("single_hold_result", rsp0_result, 32'd12);

    // Backpressure: consume-and-overwrite, then block req0 behind a full slot.
    rsp0_ready = 1;
    req0_valid = 1; req0_op1 = 4; req0_op2 = 4;
    #1;
    check("bp_req0_ready", 32'(req0_ready), 32'd1);
    tick();
    check("bp_rsp0_result", rsp0_result, 32'd8);
    check("bp_rsp0_valid", 32'(rsp0_valid), 32'd1);
    rsp0_ready = 0;
    req0_op1 = 6; req0_op2 = 6;
    req1_valid = 1; req1_op1 = 1; req1_op2 = 1;
    #1;
    check("bp_req0_blocked", 32'(req0_ready), 32'd0);
    check("bp_req1_ready", 32'(req1_ready), 32'd1);
    tick();
    check("bp_rsp1_result", rsp1_result, 32'd2);
    check("bp_rsp1_flags", 32'(rsp1_flags), 32'h2);
    check("bp_rsp0_held", rsp0_result, 32'd8);
    req1_valid = 0;
    #1;
    check("bp_req0_still_blocked", 32'(req0_ready), 32'd0);
    tick();
    check("bp_rsp0_held2", rsp0_result, 32'd8);
    rsp0_ready = 1;
    #1;
    check("bp_release_req0_ready", 32'(req0_ready), 32'd1);
    tick();
    check("bp_overwrite_valid", 32'(rsp0_valid), 32'd1);
    check("bp_overwrite_result", rsp0_result, 32'd12);
    req0_valid = 0; rsp1_ready = 1;
    tick();
    check("bp_drain_rsp0", 32'(rsp0_valid), 32'd0);
    check("bp_drain_rsp1", 32'(rsp1_valid), 32'd0);

    // Zero flag.
    rsp0_ready = 0; rsp1_ready = 0;
    req1_valid = 1; req1_op1 = 3; req1_op2 = 32'hFFFF_FFFD;
    tick();
    req1_valid = 0;
    check("zero_rsp1_result", rsp1_result, 32'd0);
    check("zero_flag_bit", 32'(rsp1_flags[2]), 32'd1);
    check("zero_rsp1_flags", 32'(rsp1_flags), 32'h4);

    // Async reset mid-operation.
    req0_valid = 1; req0_op1 = 7; req0_op2 = 8;
    tick();
    req0_valid = 0;
    check("ar_rsp0_before", rsp0_result, 32'd15);
    #3 reset = 1;
    #1;
    check("ar_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("ar_rsp0_result", rsp0_result, 32'd0);
    check("ar_rsp1_valid", 32'(rsp1_valid), 32'd0);
    @(posedge clk);
    #2 reset = 0;
    req0_valid = 1; req0_op1 = 0; req0_op2 = 1;
    req1_valid = 1; req1_op1 = 0; req1_op2 = 2;
    #1;
    check("ar_post_req0_ready", 32'(req0_ready), 32'd1);
    check("ar_post_req1_ready", 32'(req1_ready), 32'd0);
    check("ar_post_rsp0_valid", 32'(rsp0_valid), 32'd0);
    tick();
    check("ar_post_rsp0_result", rsp0_result, 32'd1);
    check("ar_post_rsp1_valid", 32'(rsp1_valid), 32'd0);
    req0_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
    tick();
    req1_valid = 0;
    check("ar_post_rsp1_result", rsp1_result, 32'd2);
    tick();

`ifdef ALU_ARB_LOCK_EN
    // Lock: req1 keeps the ALU until it requests with lock clear.
    req1_valid = 1; req1_lock = 1; req1_op1 = 1; req1_op2 = 1;
    #1;
    check("lock_first_req1", 32'(req1_ready), 32'd1);
    tick();
    req0_valid = 1; req0_op1 = 9; req0_op2 = 9;
    #1;
    check("lock_req1_ready", 32'(req1_ready), 32'd1);
    check("lock_req0_wait", 32'(req0_ready), 32'd0);
    tick();
    req1_lock = 0;
    #1;
    check("lock_rel_req1_ready", 32'(req1_ready), 32'd1);
    check("lock_rel_req0_wait", 32'(req0_ready), 32'd0);
    tick();
    #1;
    check("unlock_req0_ready", 32'(req0_ready), 32'd1);
    check("unlock_req1_ready", 32'(req1_ready), 32'd0);
    tick();
    req0_valid = 0; req1_valid = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
